multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Moore-style main control unit for the multicycle MIPS datapath. Decodes the 6-bit opcode held in the instruction register and steps through fetch, decode, execute, memory and write-back states. Drives every datapath enable and mux select: PC write, memory read/write, IR write, register-file write, ALU source and op.

## Interface
- No parameters.
- clock  in  1  system clock, rising-edge active
- Reset  in  1  asynchronous, active-high reset
- opcode  in  6  instruction bits [31:26] from the IR
- PCWriteCond  out  1  PC write qualified by ALU zero (branch)
- PCWrite  out  1  unconditional PC write
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result register
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- MemtoReg  out  1  write-back data select: 0 = ALU result register, 1 = MDR
- IRWrite  out  1  instruction register load
- PCSource  out  2  next-PC select: 00 = ALU result, 01 = ALU result register, 10 = jump target
- ALUOp  out  2  to ALU control: 00 = add, 01 = subtract, 10 = use funct
- ALUSrcB  out  2  ALU B select: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register
- RegWrite  out  1  register-file write enable
- RegDst  out  1  destination select: 0 = rt, 1 = rd
- state  out  4  current state encoding (debug)
- instr_count  out  32  retired-instruction counter
- illegal_op  out  1  high for one cycle after an unsupported opcode is decoded

## Operation
- States and encodings:
  - RST=4'hF
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPE_EX=6, RTYPE_WB=7, BEQ=8, JUMP=9
  - ADDI_EX=10, ADDI_WB=11
- Outputs are a pure function of state. Every output not listed for a state is 0.
  - RST: all outputs 0.
  - FETCH: MemRead, IRWrite, PCWrite=1; ALUSrcB=01.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - RTYPE_EX: ALUSrcA=1, ALUOp=10.
  - RTYPE_WB: RegWrite=1, RegDst=1.
  - BEQ: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10.
  - ADDI_WB: RegWrite=1.
- Transitions:
  - RST→FETCH
  - FETCH→DECODE
  - From DECODE, by opcode:
    - 6'h00 → RTYPE_EX
    - 6'h23 (lw) or 6'h2B (sw) → MEMADR
    - 6'h04 → BEQ
    - 6'h02 → JUMP
    - 6'h08 → ADDI_EX
    - any other opcode → FETCH
  - MEMADR: → MEMRD for lw, → MEMWR for sw.
  - MEMRD→MEMWB
  - RTYPE_EX→RTYPE_WB
  - ADDI_EX→ADDI_WB
  - MEMWB, MEMWR, RTYPE_WB, BEQ, JUMP, ADDI_WB → FETCH
- Opcode is sampled in DECODE for the dispatch and again in MEMADR for the lw/sw split. The IR holds it stable because IRWrite is 0 outside FETCH.
- instr_count:
  - Increments by 1 on each transition from a terminal state (MEMWB, MEMWR, RTYPE_WB, BEQ, JUMP, ADDI_WB) to FETCH.
  - Wraps 32'hFFFFFFFF→0.
  - Illegal opcodes do not count.
- illegal_op: registered; set on the DECODE→FETCH transition caused by an illegal opcode, cleared on every other edge.

## Timing
- Reset asserted: immediately state=RST, all control outputs 0, instr_count=0, illegal_op=0. This holds regardless of the clock, including mid-instruction.
- First rising edge after Reset deasserts: state=FETCH.
- Latency from FETCH entry to the next FETCH entry: lw 5 cycles; sw, R-type and addi 4; beq and j 3; illegal opcode 2.
- instr_count updates on the same edge that enters FETCH.
- illegal_op is high during exactly that FETCH cycle.
- Reset deasserted coincident with a clock edge: the FSM stays in RST for that edge and enters FETCH on the following edge.

## Configuration
- MULTICYCLE_ADDI_EN
  - Defined: opcode 6'h08 dispatches to ADDI_EX→ADDI_WB and counts as retired.
  - Undefined: ADDI_EX and ADDI_WB are not built; 6'h08 is treated as illegal (DECODE→FETCH, illegal_op pulse, no count).

## Test plan
- Reset mid-RTYPE_EX: all control outputs 0 and state=4'hF within the same cycle; FETCH reached one edge after release; instr_count=0.
- opcode=6'h23 held: state sequence 0,1,2,3,4,0. MEMRD asserts MemRead=1 and IorD=1. MEMWB asserts RegWrite=1 and MemtoReg=1. instr_count becomes 1 on re-entry to FETCH.
- opcode=6'h2B: sequence 0,1,2,5,0 with MemWrite=1 and IorD=1 in MEMWR; RegWrite never asserted.
- opcode=6'h04 then 6'h02:
  - BEQ cycle shows PCWriteCond=1, PCSource=01, ALUOp=01.
  - JUMP cycle shows PCWrite=1, PCSource=10.
  - Count increases by 2 after 6 cycles.
- opcode=6'h3F: sequence 0,1,0 with illegal_op=1 in the second FETCH only; instr_count unchanged.
- Preload the counter to 32'hFFFFFFFF by running back-to-back R-type instructions (force in sim); the next retirement yields 0. opcode=6'h08 reaches state 11 only with MULTICYCLE_ADDI_EN defined; otherwise it raises illegal_op.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath: opcode dispatch, datapath controls, retire counter.
// Define MULTICYCLE_ADDI_EN to build the addi execute/write-back states; otherwise opcode 6'h08 is illegal.
module multicycle_control_fsm (
    input  logic        clock,
    input  logic        Reset,
    input  logic [5:0]  opcode,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [3:0]  state,
    output logic [31:0] instr_count,
    output logic        illegal_op
);

    typedef enum logic [3:0] {
        FETCH    = 4'h0, DECODE   = 4'h1, MEMADR   = 4'h2, MEMRD   = 4'h3,
        MEMWB    = 4'h4, MEMWR    = 4'h5, RTYPE_EX = 4'h6, RTYPE_WB = 4'h7,
        BEQ      = 4'h8, JUMP     = 4'h9, ADDI_EX  = 4'hA, ADDI_WB  = 4'hB,
        RST      = 4'hF
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    state_t cur, nxt;
    logic   dec_illegal;
    logic   retire;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) cur <= RST;
        else       cur <= nxt;
    end

    always_comb begin
        nxt         = FETCH;
        dec_illegal = 1'b0;
        case (cur)
            RST:      nxt = FETCH;
            FETCH:    nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:         nxt = RTYPE_EX;
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_BEQ:       nxt = BEQ;
                    OP_J:         nxt = JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      nxt = ADDI_EX;
`else
                    OP_ADDI: begin
                        nxt         = FETCH;
                        dec_illegal = 1'b1;
                    end
`endif
                    default: begin
                        nxt         = FETCH;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            // IR is frozen outside FETCH, so the opcode still selects lw vs sw here
            MEMADR:   nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    nxt = MEMWB;
            RTYPE_EX: nxt = RTYPE_WB;
`ifdef MULTICYCLE_ADDI_EN
            ADDI_EX:  nxt = ADDI_WB;
`endif
            default:  nxt = FETCH;
        endcase
    end

    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            RTYPE_EX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`ifdef MULTICYCLE_ADDI_EN
            ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDI_WB:  RegWrite = 1'b1;
`endif
            default: ;
        endcase
    end

    // Every terminal state's only successor is FETCH, so being in one means retiring this edge
    assign retire = (cur == MEMWB) || (cur == MEMWR) || (cur == RTYPE_WB) ||
                    (cur == BEQ) || (cur == JUMP) || (cur == ADDI_WB);

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            instr_count <= 32'd0;
            illegal_op  <= 1'b0;
        end else begin
            if (retire) instr_count <= instr_count + 32'd1;
            illegal_op <= (cur == DECODE) && dec_illegal;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: expected state/count/illegal per cycle are queued at issue and checked every cycle.
module tb_multicycle_control_fsm;

    logic        clock, Reset;
    logic [5:0]  opcode;
    logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic        ALUSrcA, RegWrite, RegDst;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic        illegal_op;

    multicycle_control_fsm dut (
        .clock(clock), .Reset(Reset), .opcode(opcode),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .state(state), .instr_count(instr_count),
        .illegal_op(illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  st;
        logic [31:0] cnt;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] exp_cnt;
    int          n_chk, n_pass;
    logic [15:0] ctl;

    assign ctl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst};

    // Control word expected in each state, written out from the state/output table
    function automatic logic [15:0] exp_ctl(input logic [3:0] s);
        logic pcwc, pcw, iord, mr, mw, m2r, irw, srca, rw, rd;
        logic [1:0] pcs, aop, srcb;
        {pcwc, pcw, iord, mr, mw, m2r, irw, srca, rw, rd} = '0;
        {pcs, aop, srcb} = '0;
        case (s)
            4'h0: begin mr = 1; irw = 1; pcw = 1; srcb = 2'b01; end
            4'h1: srcb = 2'b11;
            4'h2: begin srca = 1; srcb = 2'b10; end
            4'h3: begin mr = 1; iord = 1; end
            4'h4: begin rw = 1; m2r = 1; end
            4'h5: begin mw = 1; iord = 1; end
            4'h6: begin srca = 1; aop = 2'b10; end
            4'h7: begin rw = 1; rd = 1; end
            4'h8: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'h9: begin pcw = 1; pcs = 2'b10; end
            4'hA: begin srca = 1; srcb = 2'b10; end
            4'hB: rw = 1;
            default: ;
        endcase
        return {pcwc, pcw, iord, mr, mw, m2r, irw, pcs, aop, srcb, srca, rw, rd};
    endfunction

    always @(posedge clock) begin
        #1;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            n_chk++;
            if (state !== mon_e.st) $display("FAIL sb_state: got %h want %h", state, mon_e.st);
            else n_pass++;
            n_chk++;
            if (ctl !== exp_ctl(mon_e.st))
                $display("FAIL sb_ctl st=%h: got %h want %h", mon_e.st, ctl, exp_ctl(mon_e.st));
            else n_pass++;
            n_chk++;
            if (instr_count !== mon_e.cnt)
                $display("FAIL sb_count: got %h want %h", instr_count, mon_e.cnt);
            else n_pass++;
            n_chk++;
            if (illegal_op !== mon_e.ill)
                $display("FAIL sb_illegal: got %b want %b", illegal_op, mon_e.ill);
            else n_pass++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Queue the state walk from the current FETCH back to FETCH and drive the opcode
    task automatic issue(input logic [5:0] op, output int len);
        logic [3:0] seq[$];
        bit   retire, illegal;
        exp_t e;
        seq = {4'h1};
        retire = 1'b1;
        illegal = 1'b0;
        case (op)
            6'h00: begin seq.push_back(4'h6); seq.push_back(4'h7); end
            6'h23: begin seq.push_back(4'h2); seq.push_back(4'h3); seq.push_back(4'h4); end
            6'h2B: begin seq.push_back(4'h2); seq.push_back(4'h5); end
            6'h04: seq.push_back(4'h8);
            6'h02: seq.push_back(4'h9);
`ifdef MULTICYCLE_ADDI_EN
            6'h08: begin seq.push_back(4'hA); seq.push_back(4'hB); end
`endif
            default: begin retire = 1'b0; illegal = 1'b1; end
        endcase
        seq.push_back(4'h0);
        for (int i = 0; i < seq.size(); i++) begin
            e.st = seq[i];
            e.ill = 1'b0;
            if (i == seq.size() - 1) begin
                if (retire) exp_cnt = exp_cnt + 32'd1;
                e.ill = illegal;
            end
            e.cnt = exp_cnt;
            q.push_back(e);
        end
        opcode = op;
        len = seq.size();
    endtask

    task automatic test_reset();
        exp_t e;
        Reset = 1'b0;
        opcode = 6'h00;
        exp_cnt = 32'd0;
        #1 Reset = 1'b1;
        #2;
        n_chk++;
        if (state !== 4'hF || ctl !== 16'h0 || instr_count !== 32'd0 || illegal_op !== 1'b0)
            $display("FAIL reset_state: got st=%h ctl=%h cnt=%h ill=%b want st=f ctl=0 cnt=0 ill=0",
                     state, ctl, instr_count, illegal_op);
        else n_pass++;
        tick();
        Reset = 1'b0;
        e.st = 4'h0; e.cnt = 32'd0; e.ill = 1'b0;
        q.push_back(e);
        tick();
    endtask

    task automatic test_lw();
        int len;
        issue(6'h23, len);
        tick(); tick(); tick();
        n_chk++;
        if (MemRead !== 1'b1 || IorD !== 1'b1)
            $display("FAIL lw_memrd: got MemRead=%b IorD=%b want 1 1", MemRead, IorD);
        else n_pass++;
        tick();
        n_chk++;
        if (RegWrite !== 1'b1 || MemtoReg !== 1'b1)
            $display("FAIL lw_memwb: got RegWrite=%b MemtoReg=%b want 1 1", RegWrite, MemtoReg);
        else n_pass++;
        tick();
        n_chk++;
        if (instr_count !== 32'd1) $display("FAIL lw_count: got %0d want 1", instr_count);
        else n_pass++;
    endtask

    task automatic test_sw();
        int len;
        bit rw_seen;
        rw_seen = 1'b0;
        issue(6'h2B, len);
        for (int i = 0; i < len; i++) begin
            tick();
            if (RegWrite !== 1'b0) rw_seen = 1'b1;
            if (i == 2) begin
                n_chk++;
                if (MemWrite !== 1'b1 || IorD !== 1'b1 || state !== 4'h5)
                    $display("FAIL sw_memwr: got st=%h MemWrite=%b IorD=%b want 5 1 1",
                             state, MemWrite, IorD);
                else n_pass++;
            end
        end
        n_chk++;
        if (rw_seen) $display("FAIL sw_regwrite: got RegWrite=1 during sw want 0");
        else n_pass++;
    endtask

    task automatic test_beq_jump();
        int len;
        logic [31:0] start;
        start = exp_cnt;
        issue(6'h04, len);
        tick(); tick();
        n_chk++;
        if (PCWriteCond !== 1'b1 || PCSource !== 2'b01 || ALUOp !== 2'b01)
            $display("FAIL beq_ctl: got PCWriteCond=%b PCSource=%b ALUOp=%b want 1 01 01",
                     PCWriteCond, PCSource, ALUOp);
        else n_pass++;
        tick();
        issue(6'h02, len);
        tick(); tick();
        n_chk++;
        if (PCWrite !== 1'b1 || PCSource !== 2'b10)
            $display("FAIL jump_ctl: got PCWrite=%b PCSource=%b want 1 10", PCWrite, PCSource);
        else n_pass++;
        tick();
        n_chk++;
        if (instr_count !== start + 32'd2)
            $display("FAIL beq_jump_count: got %0d want %0d", instr_count, start + 32'd2);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int len;
        logic [31:0] start;
        start = exp_cnt;
        issue(6'h3F, len);
        tick();
        n_chk++;
        if (illegal_op !== 1'b0) $display("FAIL illegal_decode: got %b want 0", illegal_op);
        else n_pass++;
        tick();
        n_chk++;
        if (illegal_op !== 1'b1 || state !== 4'h0 || instr_count !== start)
            $display("FAIL illegal_fetch: got ill=%b st=%h cnt=%0d want 1 0 %0d",
                     illegal_op, state, instr_count, start);
        else n_pass++;
        issue(6'h00, len);
        tick();
        n_chk++;
        if (illegal_op !== 1'b0) $display("FAIL illegal_clear: got %b want 0", illegal_op);
        else n_pass++;
        for (int i = 1; i < len; i++) tick();
    endtask

    task automatic test_reset_mid();
        int len;
        exp_t e;
        issue(6'h00, len);
        tick(); tick();
        n_chk++;
        if (state !== 4'h6) $display("FAIL mid_pre: got st=%h want 6", state);
        else n_pass++;
        Reset = 1'b1;
        q.delete();
        #1;
        n_chk++;
        if (state !== 4'hF || ctl !== 16'h0 || instr_count !== 32'd0 || illegal_op !== 1'b0)
            $display("FAIL mid_reset: got st=%h ctl=%h cnt=%h ill=%b want f 0 0 0",
                     state, ctl, instr_count, illegal_op);
        else n_pass++;
        tick();
        n_chk++;
        if (state !== 4'hF) $display("FAIL mid_hold: got st=%h want f", state);
        else n_pass++;
        Reset = 1'b0;
        exp_cnt = 32'd0;
        e.st = 4'h0; e.cnt = 32'd0; e.ill = 1'b0;
        q.push_back(e);
        tick();
    endtask

    task automatic test_wrap();
        int len;
        for (int k = 0; k < 3; k++) begin
            issue(6'h00, len);
            for (int i = 0; i < len; i++) tick();
        end
        force dut.instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count;
        exp_cnt = 32'hFFFF_FFFF;
        issue(6'h00, len);
        for (int i = 0; i < len; i++) tick();
        n_chk++;
        if (instr_count !== 32'd0) $display("FAIL wrap: got %h want 0", instr_count);
        else n_pass++;
    endtask

    task automatic test_addi();
        int len;
        bit saw_wb, saw_ill;
        logic [31:0] start;
        start = exp_cnt;
        saw_wb = 1'b0;
        saw_ill = 1'b0;
        issue(6'h08, len);
        for (int i = 0; i < len; i++) begin
            tick();
            if (state === 4'hB) saw_wb = 1'b1;
            if (illegal_op === 1'b1) saw_ill = 1'b1;
        end
        n_chk++;
`ifdef MULTICYCLE_ADDI_EN
        if (!saw_wb || saw_ill || instr_count !== start + 32'd1)
            $display("FAIL addi: got wb=%b ill=%b cnt=%0d want 1 0 %0d",
                     saw_wb, saw_ill, instr_count, start + 32'd1);
        else n_pass++;
`else
        if (saw_wb || !saw_ill || instr_count !== start)
            $display("FAIL addi: got wb=%b ill=%b cnt=%0d want 0 1 %0d",
                     saw_wb, saw_ill, instr_count, start);
        else n_pass++;
`endif
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset();
        test_lw();
        test_sw();
        test_beq_jump();
        test_illegal();
        test_reset_mid();
        test_wrap();
        test_addi();
        n_chk++;
        if (q.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
